// File: rtl/jtag_mem_bridge_pkg.sv
// Shared constants and FSM encoding for the JTAG virtual-DR memory bridge.
package jtag_mem_bridge_pkg;

  localparam int DR_LENGTH         = 32;
  localparam int ADDR_BITS_DEFAULT = 8;
  localparam int WR_COUNT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WAIT    = 2'd2,
    ST_WRITE   = 2'd3
  } state_e;

endpackage

// File: rtl/jtag_dpram.sv
// Simple dual-port RAM: synchronous write on port A, registered 1-cycle read on port B.
module jtag_dpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] b_rdata_q;

  // Read-before-write: a same-cycle read of the address being written returns old data.
  always_ff @(posedge clk) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
    b_rdata_q <= mem_q[b_addr_i];
  end

  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/jtag_mem_bridge.sv
// TCK-to-clk write bridge and buffer RAM behind the JTAG virtual DR.
// Optional host address auto-increment is enabled with `define JTAG_MEM_AUTOINC_EN.
module jtag_mem_bridge
  import jtag_mem_bridge_pkg::*;
#(
  parameter int DR_LENGTH = jtag_mem_bridge_pkg::DR_LENGTH,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wram_enable,
  input  logic [DR_LENGTH-1:0]  wdata_in,
  input  logic [DR_LENGTH-1:0]  waddr_in,
  input  logic [DR_LENGTH-1:0]  raddr_in,
  output logic [DR_LENGTH-1:0]  rdata_out,
  input  logic                  sys_we,
  input  logic [ADDR_BITS-1:0]  sys_waddr,
  input  logic [DR_LENGTH-1:0]  sys_wdata,
  output logic                  host_wr_pulse,
  output logic [WR_COUNT_W-1:0] host_wr_count,
  output logic                  busy
);

  logic                  sync1_q, sync2_q, prev_q;
  logic                  wr_req;
  state_e                state_q, state_d;
  logic                  host_we;
  logic [ADDR_BITS-1:0]  cap_sel;
  logic [ADDR_BITS-1:0]  cap_addr_q;
  logic [DR_LENGTH-1:0]  cap_data_q;
  logic [WR_COUNT_W-1:0] wr_count_q, wr_count_d;
  logic [ADDR_BITS-1:0]  raddr_s1_q, raddr_s2_q, raddr_acc_q;
  logic [DR_LENGTH-1:0]  ram_rdata;
  logic                  ram_a_we;
  logic [ADDR_BITS-1:0]  ram_a_addr;
  logic [DR_LENGTH-1:0]  ram_a_wdata;
  logic                  unused_upper_bits;

  assign unused_upper_bits = ^{waddr_in[DR_LENGTH-1:ADDR_BITS], raddr_in[DR_LENGTH-1:ADDR_BITS]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= wram_enable;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign wr_req = sync2_q & ~prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
    end
  end

  // System writes own port A; a host write that meets sys_we falls back to WAIT.
  always_comb begin
    state_d = state_q;
    host_we = 1'b0;
    case (state_q)
      ST_IDLE:    if (wr_req) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = sys_we ? ST_WAIT : ST_WRITE;
      ST_WAIT:    if (!sys_we) state_d = ST_WRITE;
      ST_WRITE: begin
        if (sys_we) begin
          state_d = ST_WAIT;
        end else begin
          host_we = ~reset;
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  assign wr_count_d = host_we ? wr_count_q + 16'd1 : wr_count_q;

`ifdef JTAG_MEM_AUTOINC_EN
  logic [ADDR_BITS-1:0] ptr_q, last_waddr_q;

  assign cap_sel = (waddr_in[ADDR_BITS-1:0] != last_waddr_q) ? waddr_in[ADDR_BITS-1:0] : ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      last_waddr_q <= '0;
    end else begin
      if (state_q == ST_CAPTURE) last_waddr_q <= waddr_in[ADDR_BITS-1:0];
      if (host_we) ptr_q <= cap_addr_q + 1'b1;
    end
  end
`else
  assign cap_sel = waddr_in[ADDR_BITS-1:0];
`endif

  always_ff @(posedge clk) begin
    if (state_q == ST_CAPTURE) begin
      cap_addr_q <= cap_sel;
      cap_data_q <= wdata_in;
    end
  end

  assign ram_a_we    = sys_we | host_we;
  assign ram_a_addr  = sys_we ? sys_waddr : cap_addr_q;
  assign ram_a_wdata = sys_we ? sys_wdata : cap_data_q;

  // Only an address seen identically on two consecutive samples reaches port B.
  always_ff @(posedge clk) begin
    raddr_s1_q <= raddr_in[ADDR_BITS-1:0];
    raddr_s2_q <= raddr_s1_q;
    if (raddr_s1_q == raddr_s2_q) raddr_acc_q <= raddr_s2_q;
  end

  jtag_dpram #(
    .DATA_W (DR_LENGTH),
    .ADDR_W (ADDR_BITS)
  ) u_ram (
    .clk       (clk),
    .a_we_i    (ram_a_we),
    .a_addr_i  (ram_a_addr),
    .a_wdata_i (ram_a_wdata),
    .b_addr_i  (raddr_acc_q),
    .b_rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) rdata_out <= '0;
    else       rdata_out <= ram_rdata;
  end

  assign host_wr_pulse = host_we;
  assign host_wr_count = wr_count_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Directed, table-driven bench for jtag_mem_bridge; write/read model kept in the bench.
module tb_jtag_mem_bridge;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wram_enable;
  logic [DW-1:0] wdata_in, waddr_in, raddr_in;
  logic [DW-1:0] rdata_out;
  logic          sys_we;
  logic [AW-1:0] sys_waddr;
  logic [DW-1:0] sys_wdata;
  logic          host_wr_pulse;
  logic [15:0]   host_wr_count;
  logic          busy;

  always #5 clk = ~clk;

  jtag_mem_bridge #(.DR_LENGTH(DW), .ADDR_BITS(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .wram_enable   (wram_enable),
    .wdata_in      (wdata_in),
    .waddr_in      (waddr_in),
    .raddr_in      (raddr_in),
    .rdata_out     (rdata_out),
    .sys_we        (sys_we),
    .sys_waddr     (sys_waddr),
    .sys_wdata     (sys_wdata),
    .host_wr_pulse (host_wr_pulse),
    .host_wr_count (host_wr_count),
    .busy          (busy)
  );

  typedef struct {
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  vec_t          tbl [4];
  logic [DW-1:0] mem_m [256];
  logic [15:0]   exp_count;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Raise the strobe for one TCK (4 clk) and watch host_wr_pulse for ncyc cycles.
  task automatic host_strobe(input logic [DW-1:0] a, input logic [DW-1:0] d, input int ncyc,
                             output int npulse, output int first);
    npulse = 0;
    first  = -1;
    @(negedge clk);
    waddr_in    = a;
    wdata_in    = d;
    wram_enable = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (i == 4) wram_enable = 1'b0;
      if (host_wr_pulse) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
    wram_enable = 1'b0;
  endtask

  task automatic host_write(input logic [DW-1:0] a, input logic [DW-1:0] d, input logic [7:0] ma);
    int np, fi;
    host_strobe(a, d, 14, np, fi);
    mem_m[ma] = d;
    exp_count = exp_count + 16'd1;
    check("wr_pulse_count", np, 1);
    check("wr_pulse_latency", fi, 4);
    check("wr_count", {16'd0, host_wr_count}, {16'd0, exp_count});
  endtask

  task automatic sys_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    sys_we = 1'b1; sys_waddr = a; sys_wdata = d;
    @(negedge clk);
    sys_we = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a);
    @(negedge clk);
    raddr_in = {24'hA5A5A5, a};
    repeat (5) @(negedge clk);
    check(name, rdata_out, mem_m[a]);
  endtask

  initial begin
    int np, fi;
    bit seen_glitch;
    logic [DW-1:0] old_val;

    tbl[0] = '{32'h0000_0010, 32'hDEAD_BEEF};
    tbl[1] = '{32'h0000_00FF, 32'h1234_5678};
    tbl[2] = '{32'h0000_0000, 32'hCAFE_F00D};
    tbl[3] = '{32'hFFFF_FFAB, 32'h0F0F_0F0F};

    reset = 1'b1; wram_enable = 1'b0; wdata_in = '0; waddr_in = '0; raddr_in = '0;
    sys_we = 1'b0; sys_waddr = '0; sys_wdata = '0; exp_count = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata_out, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_pulse", {31'd0, host_wr_pulse}, 0);
    check("rst_count", {16'd0, host_wr_count}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while a host write is parked in WAIT.
    sys_write(8'h31, 32'h0000_AAAA);
    @(negedge clk);
    sys_we = 1'b1; sys_waddr = 8'h30; sys_wdata = 32'h0000_3333;
    mem_m[8'h30] = 32'h0000_3333;
    host_strobe(32'h31, 32'h0000_5555, 8, np, fi);
    check("wait_busy", {31'd0, busy}, 1);
    check("wait_no_pulse", np, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rstwait_busy", {31'd0, busy}, 0);
    check("rstwait_count", {16'd0, host_wr_count}, 0);
    check("rstwait_rdata", rdata_out, 0);
    reset = 1'b0;
    sys_we = 1'b0;
    repeat (6) @(negedge clk);
    check("rstwait_idle", {31'd0, busy}, 0);
    check("rstwait_count2", {16'd0, host_wr_count}, 0);
    read_check("rstwait_lost", 8'h31);
    read_check("rstwait_sys", 8'h30);

    for (int i = 0; i < 4; i++) begin
      host_write(tbl[i].addr, tbl[i].data, tbl[i].addr[7:0]);
      read_check("tbl_readback", tbl[i].addr[7:0]);
    end

    // One-cycle skewed read address must never surface.
    sys_write(8'h11, 32'h1111_1111);
    sys_write(8'h12, 32'hBADB_AD00);
    read_check("glitch_pre", 8'h10);
    @(negedge clk); raddr_in = 32'h12;
    @(negedge clk); raddr_in = 32'h11;
    seen_glitch = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rdata_out === 32'hBADB_AD00) seen_glitch = 1'b1;
    end
    check("glitch_seen", {31'd0, seen_glitch}, 0);
    check("glitch_final", rdata_out, 32'h1111_1111);

    // System write with a same-cycle read of the same address.
    sys_write(8'h40, 32'h0000_0DD0);
    read_check("sw_pre", 8'h40);
    old_val = mem_m[8'h40];
    @(negedge clk); sys_we = 1'b1; sys_waddr = 8'h40; sys_wdata = 32'h0000_0E0E;
    @(negedge clk); sys_we = 1'b0;
    @(negedge clk); check("sw_old", rdata_out, old_val);
    @(negedge clk); check("sw_new", rdata_out, 32'h0000_0E0E);
    mem_m[8'h40] = 32'h0000_0E0E;

    // Collision: host write deferred behind a held sys_we.
    @(negedge clk);
    sys_we = 1'b1; sys_waddr = 8'h20; sys_wdata = 32'h0000_1111;
    host_strobe(32'h21, 32'h0000_2222, 12, np, fi);
    check("coll_busy", {31'd0, busy}, 1);
    check("coll_no_pulse", np, 0);
    check("coll_count_held", {16'd0, host_wr_count}, {16'd0, exp_count});
    sys_we = 1'b0;
    mem_m[8'h20] = 32'h0000_1111;
    mem_m[8'h21] = 32'h0000_2222;
    exp_count = exp_count + 16'd1;
    np = 0; fi = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (host_wr_pulse) begin
        np++;
        if (fi < 0) fi = i;
      end
    end
    check("coll_pulse", np, 1);
    check("coll_pulse_at", fi, 1);
    check("coll_count", {16'd0, host_wr_count}, {16'd0, exp_count});
    read_check("coll_sys", 8'h20);
    read_check("coll_host", 8'h21);

`ifdef JTAG_MEM_AUTOINC_EN
    host_write(32'hFE, 32'h1, 8'hFE);
    host_write(32'hFE, 32'h2, 8'hFF);
    host_write(32'hFE, 32'h3, 8'h00);
`else
    host_write(32'hFE, 32'h1, 8'hFE);
    host_write(32'hFE, 32'h2, 8'hFE);
    host_write(32'hFE, 32'h3, 8'hFE);
`endif
    read_check("stream_fe", 8'hFE);
    read_check("stream_ff", 8'hFF);
    read_check("stream_00", 8'h00);

    // Counter wrap: preload near the top rather than issuing 64K strobes.
    @(negedge clk);
    force dut.wr_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.wr_count_q;
    exp_count = 16'hFFFE;
    host_write(32'h50, 32'h0000_5050, 8'h50);
    check("wrap_ffff", {16'd0, host_wr_count}, 32'h0000_FFFF);
    host_write(32'h51, 32'h0000_5151, 8'h51);
    check("wrap_zero", {16'd0, host_wr_count}, 0);
    read_check("wrap_data", 8'h51);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_mem_bridge.md
# jtag_mem_bridge

Clock-domain bridge and buffer memory sitting directly downstream of the JTAG virtual-DR top level. It synchronises the TCK-domain write strobe into the system clock domain and commits host writes to an internal dual-port RAM. It continuously serves host reads from that RAM back into the read-data register. A system-side write port lets on-chip logic deposit words for the host to read.

## Interface

- `DR_LENGTH`, 32: data/address word width, matching the virtual DR length.
- `ADDR_BITS`, 8: RAM depth is 2^ADDR_BITS words; the low ADDR_BITS of every address are used, upper bits are ignored.

Ports. One clock; reset is synchronous and active-high.

- `clk`  in  1  system clock; must run at least 4× TCK.
- `reset`  in  1  synchronous, active-high.
- `wram_enable`  in  1  TCK-domain write strobe, asynchronous to `clk`.
- `wdata_in`  in  DR_LENGTH  host write data; quasi-static, stable while `wram_enable` is high.
- `waddr_in`  in  DR_LENGTH  host write address; quasi-static.
- `raddr_in`  in  DR_LENGTH  host read address; quasi-static.
- `rdata_out`  out  DR_LENGTH  registered read data returned to the JTAG read-data register.
- `sys_we`  in  1  system write enable, one word per cycle.
- `sys_waddr`  in  ADDR_BITS  system write address.
- `sys_wdata`  in  DR_LENGTH  system write data.
- `host_wr_pulse`  out  1  one-cycle pulse per committed host write.
- `host_wr_count`  out  16  count of committed host writes; wraps 0xFFFF→0.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation

- `wram_enable` passes through a 2-flop synchroniser, then a third flop. A rising edge (sync=1, prev=0) is a write request.
- FSM states: IDLE, CAPTURE, WAIT, WRITE.
  - IDLE → CAPTURE on a write request.
  - CAPTURE: registers `wdata_in` and the write address, then → WRITE. If `sys_we` is high in the same cycle, it goes → WAIT instead.
  - WAIT: holds while `sys_we` is high; → WRITE on the first cycle `sys_we` is low.
  - WRITE: drives RAM port A with the captured word, pulses `host_wr_pulse`, increments `host_wr_count`, then → IDLE.
- RAM port A arbitration: `sys_we` has priority. A host write is never dropped, only deferred.
- A new request arriving while not in IDLE is ignored. The host protocol guarantees spacing of at least 8 clk between strobes.
- Read path: `raddr_in` is sampled every cycle into two cascaded registers. The address is accepted only when both stages are equal, which rejects multi-bit CDC skew. The accepted address drives RAM port B (1-cycle read), and the result is registered into `rdata_out`.
- Reset: FSM to IDLE. `rdata_out`=0, `host_wr_pulse`=0, `host_wr_count`=0, `busy`=0, synchroniser flops=0. RAM contents are not cleared.
- Reset during WAIT or WRITE abandons the pending host write, with no RAM update.

## Timing

- Host write: the RAM is written 5 clk after `wram_enable` rises at the pin (2 sync + edge + CAPTURE + WRITE), plus any WAIT cycles.
- `host_wr_pulse` is coincident with the RAM write cycle.
- Host read: after `raddr_in` settles, `rdata_out` is valid within 5 clk (2 sample + compare + RAM + output register).
- A write to address A shows on `rdata_out` (with `raddr_in`=A) 2 clk after the write cycle.
- System write: 1-cycle latency into the RAM. Same-cycle read of the same address returns old data.

## Configuration

- `JTAG_MEM_AUTOINC_EN` defined: the bridge keeps an internal write pointer.
  - In CAPTURE, if the low ADDR_BITS of `waddr_in` differ from the last captured value, the pointer loads `waddr_in`; otherwise the pointer is used.
  - The pointer increments by 1 after each WRITE, wrapping at 2^ADDR_BITS.
  - This lets the host stream data without rescanning the address.
- Not defined: every host write uses the low ADDR_BITS of `waddr_in` directly, and the pointer logic is absent.

## Structure

- The shared package/defines header holds `DR_LENGTH`, the default `ADDR_BITS`, and the FSM state encoding constants.
- One sub-module, `jtag_dpram`: a simple dual-port RAM with synchronous write on port A and a registered 1-cycle read on port B.
- The synchroniser, FSM and address-stability logic stay in the top module.

## Test plan

- Host write: waddr=0x10, wdata=0xDEADBEEF, `wram_enable` high for 1 TCK at clk=4×TCK. Then RAM[0x10]=0xDEADBEEF, `host_wr_pulse` fires once, and `host_wr_count`=1.
- Read-back: set raddr=0x10. Within 5 clk, `rdata_out`=0xDEADBEEF. Switch raddr to 0x11 with a one-cycle skewed glitch value; `rdata_out` never shows the glitch address's data.
- Collision: hold `sys_we`=1 (addr 0x20, data 0x1111) across a host write to 0x21 with data 0x2222. The FSM sits in WAIT until `sys_we` drops; both words are present afterwards.
- With `JTAG_MEM_AUTOINC_EN`: waddr=0xFE, then three host writes of 1, 2, 3. Result is RAM[0xFE]=1, RAM[0xFF]=2, RAM[0x00]=3 (wrap).
- Reset is asserted while in WAIT: the pending write is lost, `busy`=0, `host_wr_count` is unchanged at 0, and `rdata_out`=0.
- 0xFFFF host writes followed by one more: `host_wr_count` wraps to 0.
